// File: rtl/prog_sequencer.sv
// Program sequencer: walks the enabled programs in ascending order, holds the core
// in start for HOLD_CYC cycles per program, then times each run until core_done.
module prog_sequencer #(
  parameter int NUM_PROG = 3,
  parameter int PC_W     = 10,
  parameter int CNT_W    = 16,
  parameter int HOLD_CYC = 2
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            go,
  input  logic [NUM_PROG-1:0]                             prog_mask,
  input  logic [NUM_PROG*PC_W-1:0]                        start_pc_tbl,
  input  logic                                            core_done,
  output logic                                            core_start,
  output logic [PC_W-1:0]                                 core_pc,
  output logic [((NUM_PROG > 1) ? $clog2(NUM_PROG) : 1)-1:0] prog_idx,
  output logic [CNT_W-1:0]                                cyc_cnt,
  output logic                                            cnt_valid,
  output logic                                            busy,
  output logic                                            all_done,
  output logic [NUM_PROG-1:0]                             err
);

  localparam int IDX_W = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_NEXT = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [3:0]       HOLD_LAST = 4'(HOLD_CYC - 1);

  logic [2:0]               state;
  logic [3:0]               hold_cnt;
  logic [NUM_PROG-1:0]      mask_q;
  logic [NUM_PROG*PC_W-1:0] pc_tbl_q;

  logic             first_found;
  logic [IDX_W-1:0] first_idx;
  logic             next_found;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] load_idx;
  logic [PC_W-1:0]  load_pc;
  logic             accept_go;

  // Lowest enabled index of the incoming mask (used on go) and of the latched
  // mask above the current program (used from NEXT).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_PROG - 1; i >= 0; i--) begin
      if (prog_mask[i]) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(i);
      end
      if (mask_q[i] && (i > int'(prog_idx))) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(i);
      end
    end
    // On go the table is latched on the same edge, so read it straight from the port.
    if (state == S_NEXT) begin
      load_idx = next_idx;
      load_pc  = pc_tbl_q[next_idx*PC_W +: PC_W];
    end else begin
      load_idx = first_idx;
      load_pc  = start_pc_tbl[first_idx*PC_W +: PC_W];
    end
    accept_go = go && ((state == S_IDLE) || (state == S_FIN));
  end

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      mask_q     <= '0;
      pc_tbl_q   <= '0;
      core_start <= 1'b1;
      core_pc    <= '0;
      prog_idx   <= '0;
      cyc_cnt    <= '0;
      cnt_valid  <= 1'b0;
      busy       <= 1'b0;
      all_done   <= 1'b0;
      err        <= '0;
    end else begin
      cnt_valid <= 1'b0;
      case (state)
        S_IDLE, S_FIN: begin
          if (state == S_FIN) state <= S_IDLE;
          if (accept_go) begin
            mask_q   <= prog_mask;
            pc_tbl_q <= start_pc_tbl;
            err      <= '0;
            if (first_found) begin
              state    <= S_LOAD;
              prog_idx <= load_idx;
              core_pc  <= load_pc;
              cyc_cnt  <= '0;
              hold_cnt <= HOLD_LAST;
              busy     <= 1'b1;
              all_done <= 1'b0;
            end else begin
              state    <= S_FIN;
              all_done <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (hold_cnt == '0) begin
            state      <= S_RUN;
            core_start <= 1'b0;
            cyc_cnt    <= CNT_W'(1);
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        S_RUN: begin
          // Done wins over saturation on the same cycle, so err only on a pure timeout.
          if (core_done || (cyc_cnt == CNT_MAX)) begin
            state      <= S_NEXT;
            cnt_valid  <= 1'b1;
            core_start <= 1'b1;
            if (!core_done) err[prog_idx] <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          if (next_found) begin
            state    <= S_LOAD;
            prog_idx <= load_idx;
            core_pc  <= load_pc;
            cyc_cnt  <= '0;
            hold_cnt <= HOLD_LAST;
          end else begin
            state    <= S_FIN;
            busy     <= 1'b0;
            all_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboarded bench for prog_sequencer: a reference model queues the expected
// (index, count, pc) per program; a monitor pops on every cnt_valid.
module tb_prog_sequencer;

  localparam int NP   = 3;
  localparam int PW   = 10;
  localparam int HOLD = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             go = 1'b0;
  logic [NP-1:0]    prog_mask = '0;
  logic [NP*PW-1:0] start_pc_tbl = '0;
  logic             core_done = 1'b0;
  logic             core_start;
  logic [PW-1:0]    core_pc;
  logic [1:0]       prog_idx;
  logic [15:0]      cyc_cnt;
  logic             cnt_valid;
  logic             busy;
  logic             all_done;
  logic [NP-1:0]    err;

  logic             go4 = 1'b0;
  logic [NP-1:0]    prog_mask4 = 3'b001;
  logic             core_done4 = 1'b0;
  logic             core_start4;
  logic [PW-1:0]    core_pc4;
  logic [1:0]       prog_idx4;
  logic [3:0]       cyc_cnt4;
  logic             cnt_valid4;
  logic             busy4;
  logic             all_done4;
  logic [NP-1:0]    err4;

  prog_sequencer #(.NUM_PROG(NP), .PC_W(PW), .CNT_W(16), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .reset(reset), .go(go), .prog_mask(prog_mask),
    .start_pc_tbl(start_pc_tbl), .core_done(core_done), .core_start(core_start),
    .core_pc(core_pc), .prog_idx(prog_idx), .cyc_cnt(cyc_cnt), .cnt_valid(cnt_valid),
    .busy(busy), .all_done(all_done), .err(err)
  );

  prog_sequencer #(.NUM_PROG(NP), .PC_W(PW), .CNT_W(4), .HOLD_CYC(HOLD)) dut4 (
    .clk(clk), .reset(reset), .go(go4), .prog_mask(prog_mask4),
    .start_pc_tbl(30'h0000_1234), .core_done(core_done4), .core_start(core_start4),
    .core_pc(core_pc4), .prog_idx(prog_idx4), .cyc_cnt(cyc_cnt4), .cnt_valid(cnt_valid4),
    .busy(busy4), .all_done(all_done4), .err(err4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { int idx; int cnt; int pc; } exp_t;
  exp_t exp_q[$];

  int   target[NP];
  int   pcs[NP];
  logic hold_done = 1'b0;
  int   rc  = 0;
  int   target4 = 0;
  int   rc4 = 0;

  // Core models: raise done on the target-th cycle with core_start low.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      rc = 0; core_done = 1'b0;
    end else if (!core_start) begin
      rc++; core_done = (rc == target[prog_idx]);
    end else begin
      rc = 0; core_done = hold_done;
    end
    if (!reset || core_start4) begin
      rc4 = 0; core_done4 = 1'b0;
    end else begin
      rc4++; core_done4 = (rc4 == target4);
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset && cnt_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_cnt_valid", 32'(cnt_valid), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_prog_idx", 32'(prog_idx), e.idx);
        check("sb_cyc_cnt", 32'(cyc_cnt), e.cnt);
        check("sb_core_pc", 32'(core_pc), e.pc);
        check("sb_next_ctrl", {30'd0, busy, core_start}, 2'b11);
      end
    end
  end

  task automatic pulse_go();
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
  endtask

  task automatic set_progs(input logic [2:0] mask, input int t0, input int t1, input int t2,
                           input int p0, input int p1, input int p2);
    target[0] = t0; target[1] = t1; target[2] = t2;
    pcs[0] = p0; pcs[1] = p1; pcs[2] = p2;
    prog_mask = mask;
    start_pc_tbl = {PW'(p2), PW'(p1), PW'(p0)};
  endtask

  task automatic run_seq(input logic [2:0] mask, input int t0, input int t1, input int t2,
                         input int p0, input int p1, input int p2,
                         input bit extra_go, input bit done_in_load);
    int cyc, first_run, load_cyc;
    logic [2:0] loaded;
    bit done_seen, xg_sent, saw_busy, saw_run;
    set_progs(mask, t0, t1, t2, p0, p1, p2);
    hold_done = done_in_load;
    for (int i = 0; i < NP; i++)
      if (mask[i]) exp_q.push_back('{i, target[i], pcs[i]});
    pulse_go();
    cyc = 0; first_run = 0; load_cyc = 0; loaded = '0;
    done_seen = 0; xg_sent = 0; saw_busy = 0; saw_run = 0;
    while (!done_seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      go = 1'b0;
      if (busy) saw_busy = 1;
      if (!core_start) saw_run = 1;
      if (busy && core_start && !cnt_valid) begin
        loaded[prog_idx] = 1'b1;
        if (first_run == 0) load_cyc++;
        check("load_pc", 32'(core_pc), pcs[prog_idx]);
        check("load_cnt_zero", 32'(cyc_cnt), 0);
      end
      if (!core_start && first_run == 0) first_run = cyc;
      if (extra_go && !xg_sent && !core_start) begin
        go = 1'b1; xg_sent = 1;
      end
      if (all_done && !busy) done_seen = 1;
    end
    go = 1'b0;
    hold_done = 1'b0;
    check("run_completes", 32'(done_seen), 1);
    if (mask != 3'b000) begin
      check("first_run_latency", first_run, HOLD + 1);
      check("first_load_cycles", load_cyc, HOLD);
    end else begin
      check("empty_done_latency", cyc, 1);
      check("empty_never_busy", 32'(saw_busy), 0);
      check("empty_never_run", 32'(saw_run), 0);
    end
    check("loaded_set", 32'(loaded), 32'(mask));
    check("err_none", 32'(err), 0);
    check("sb_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("idle_after_fin", {29'd0, busy, all_done, core_start}, 3'b011);
  endtask

  task automatic run4(input int tgt, input int exp_cnt, input logic [2:0] exp_err);
    int cyc;
    target4 = tgt;
    @(posedge clk); #1 go4 = 1'b1;
    @(posedge clk); #1 go4 = 1'b0;
    cyc = 0;
    while (!cnt_valid4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_cnt_valid_seen", 32'(cnt_valid4), 1);
    check("t4_cyc_cnt", 32'(cyc_cnt4), exp_cnt);
    check("t4_err", 32'(err4), 32'(exp_err));
    check("t4_prog_idx", 32'(prog_idx4), 0);
    @(negedge clk);
    check("t4_fin", {30'd0, all_done4, busy4}, 2'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run_cnt;
    #2 reset = 1'b0;
    #1;
    check("rst_outputs", {core_start, busy, all_done, cnt_valid, err}, 7'b1000000);
    check("rst_counters", {4'(core_pc), 2'(prog_idx), 16'(cyc_cnt)}, 0);
    check("rst4_outputs", {core_start4, busy4, all_done4, cnt_valid4, err4}, 7'b1000000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("no_self_start", {29'd0, busy, all_done, core_start}, 3'b001);

    // V1, V2, V3
    run_seq(3'b111, 10, 20, 30, 0, 40, 80, 0, 0);
    run_seq(3'b010, 5, 7, 9, 0, 40, 80, 0, 0);
    run_seq(3'b000, 5, 7, 9, 1, 2, 3, 0, 0);

    // V4 plus the done/saturation tie and a plain done just below saturation.
    run4(0, 15, 3'b001);
    run4(15, 15, 3'b000);
    run4(14, 14, 3'b000);

    // V6: extra go during RUN, done held high across NEXT/LOAD.
    run_seq(3'b111, 6, 3, 8, 11, 22, 33, 1, 1);

    // V5: reset on the 5th RUN cycle of program 1.
    set_progs(3'b111, 10, 20, 30, 0, 40, 80);
    exp_q.push_back('{0, 10, 0});
    pulse_go();
    run_cnt = 0;
    for (int c = 0; c < 200 && run_cnt < 5; c++) begin
      @(negedge clk);
      if (!core_start && prog_idx == 2'd1) run_cnt++;
    end
    check("v5_reached_run", run_cnt, 5);
    reset = 1'b0;
    #1;
    check("v5_rst_outputs", {core_start, busy, all_done, cnt_valid, err}, 7'b1000000);
    check("v5_rst_counters", {6'd0, 10'(core_pc), 16'(cyc_cnt)}, 0);
    check("v5_rst_idx", 32'(prog_idx), 0);
    check("v5_sb_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("v5_waits_idle", {29'd0, busy, all_done, core_start}, 3'b001);
    run_seq(3'b111, 4, 5, 6, 0, 40, 80, 0, 0);

    // Randomized runs.
    for (int n = 0; n < 12; n++) begin
      run_seq(3'($urandom_range(0, 7)),
              int'($urandom_range(1, 25)), int'($urandom_range(1, 25)), int'($urandom_range(1, 25)),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameters SHALL be:
- NUM_PROG, default 3, number of programs sequenced.
- PC_W, default 10, instruction-address width.
- CNT_W, default 16, cycle-counter width.
- HOLD_CYC, default 2, cycles the core is held in start per program (legal range 1..15).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  start request for one run of all enabled programs.
- prog_mask  in  NUM_PROG  per-program enable; bit i enables program i.
- start_pc_tbl  in  NUM_PROG*PC_W  start PCs; program i occupies bits [i*PC_W +: PC_W].
- core_done  in  1  done level from the core.
- core_start  out  1  active-high hold/restart to the core.
- core_pc  out  PC_W  start PC presented to the core.
- prog_idx  out  clog2(NUM_PROG)  index of the current or last program.
- cyc_cnt  out  CNT_W  cycle count of the current or last program.
- cnt_valid  out  1  one-cycle pulse; cyc_cnt is final on that cycle.
- busy  out  1  high while a run is in progress.
- all_done  out  1  run-complete level.
- err  out  NUM_PROG  per-program timeout flags.
REQ-003 The block SHALL use one clock, clk, and an asynchronous active-low reset, reset; no other clock or reset SHALL exist.

Function
REQ-004 The FSM SHALL have exactly five states: IDLE, LOAD, RUN, NEXT, FIN.
REQ-005 IDLE: core_start=1, busy=0. When go=1, prog_mask and start_pc_tbl SHALL be latched and err SHALL be cleared. Next state SHALL be LOAD at the lowest enabled index, or FIN if the latched mask is zero.
REQ-006 LOAD: core_start=1, core_pc=latched start PC of prog_idx, cyc_cnt=0. The block SHALL stay in LOAD for exactly HOLD_CYC cycles, then go to RUN.
REQ-007 RUN: core_start=0, core_pc held. cyc_cnt SHALL increment every RUN cycle, counting from 1 on the first RUN cycle.
REQ-008 In RUN, core_done=1 SHALL end the program. The final cyc_cnt SHALL include the cycle on which done was sampled, so done on the first RUN cycle gives 1.
REQ-009 Timeout: if cyc_cnt reaches 2^CNT_W-1 in RUN without core_done, the block SHALL set err[prog_idx], hold cyc_cnt saturated, and end the program. Simultaneous done and saturation SHALL count as done, with no err.
REQ-010 NEXT (one cycle): cnt_valid=1, core_start=1. The next state SHALL be LOAD for the next higher enabled index, or FIN if there is none. cyc_cnt and prog_idx SHALL hold until the next LOAD.
REQ-011 FIN: all_done=1, core_start=1, busy=0. The block SHALL return to IDLE on the next cycle; all_done SHALL stay high in IDLE until the next accepted go.
REQ-012 busy SHALL be 1 in LOAD, RUN and NEXT only.
REQ-013 go SHALL be ignored outside IDLE and FIN.
REQ-014 go in FIN SHALL be accepted as in IDLE.
REQ-015 core_done SHALL be ignored outside RUN, including when it is still high from the previous program during LOAD.
REQ-016 Latency: go sampled in IDLE at edge k means LOAD on cycles k+1..k+HOLD_CYC and the first RUN cycle at k+HOLD_CYC+1.
REQ-017 Program order SHALL be strictly ascending index; disabled programs SHALL be skipped with zero added cycles.
REQ-018 core_start SHALL be glitch-free, driven directly from a flop.

Reset
REQ-019 While reset=0, all state SHALL clear asynchronously with these values:
- state=IDLE
- core_start=1
- core_pc=0
- prog_idx=0
- cyc_cnt=0
- cnt_valid=0
- busy=0
- all_done=0
- err=0
REQ-020 Reset asserted mid-run SHALL abandon the run with no cnt_valid pulse. After release, the block SHALL wait in IDLE for a new go.
REQ-021 Reset release SHALL NOT by itself start a run.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- V1: mask=111, PCs 0/40/80, core model raises done after 10/20/30 RUN cycles -> three cnt_valid pulses with (prog_idx, cyc_cnt) = (0,10), (1,20), (2,30), then all_done=1 and err=000.
- V2: mask=010, PC1=40 -> core_pc=40 for exactly 2 LOAD cycles, one cnt_valid with prog_idx=1, programs 0 and 2 never loaded.
- V3: mask=000 -> all_done=1 one cycle after go, busy never 1, core_start never 0.
- V4: CNT_W=4, core never done, mask=001 -> cyc_cnt=15, err=001, cnt_valid pulse, all_done=1.
- V5: reset=0 on the 5th RUN cycle of program 1 -> outputs take reset values immediately; a later go restarts at program 0.
- V6: go pulsed in RUN and core_done held high through LOAD -> the extra go is ignored, and the next program's count starts from 1 and ends only on a new in-RUN done.
